// File: rtl/sandbox_command_responder.sv
// sandbox_command_responder
// Host-side command responder for the wide UART data interface. Each received
// frame (control byte + payload) is latched and acknowledged through the
// clearDR handshake. One command then runs against an accumulator and a frame
// counter, and a reply is requested on transmitData and tracked until the UART
// interface has finished sending it.
module sandbox_command_responder #(
  parameter int WIDTH            = 7,
  parameter int TX_START_TIMEOUT = 1024
) (
  input  logic                 masterClock,
  input  logic                 reset,
  input  logic                 dataReceived,
  input  logic [7:0]           control,
  input  logic [8*WIDTH-1:0]   inputData,
  input  logic                 transmitting,
  output logic                 clearDR,
  output logic                 transmitData,
  output logic [7:0]           status,
  output logic [8*WIDTH-1:0]   outputData,
  output logic                 rxIndicator
);

  localparam int DW = 8 * WIDTH;
  localparam int TW = $clog2(TX_START_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TX_START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    CLEAR,
    SEND,
    WAIT_DONE
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP        = 4'h0,
    OP_ECHO       = 4'h1,
    OP_INVERT     = 4'h2,
    OP_ACCUMULATE = 4'h3,
    OP_READ_ACC   = 4'h4,
    OP_CLEAR_ACC  = 4'h5,
    OP_COUNT      = 4'h6
  } opcode_t;

  // Result codes reported in status[3:0].
  localparam logic [3:0] RES_OK       = 4'd0;
  localparam logic [3:0] RES_UNKNOWN  = 4'd1;
  localparam logic [3:0] RES_CARRY    = 4'd2;
  localparam logic [3:0] RES_TX_START = 4'd3;

  state_t          state;
  logic [7:0]      ctl_q;
  logic [DW-1:0]   data_q;
  logic [DW-1:0]   acc;
  logic [15:0]     cnt;
  logic [TW-1:0]   timer;
  logic [DW:0]     acc_sum;

  // Accumulator sum with its carry out, used by ACCUMULATE.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, data_q};
  end

  // Frame acceptance, command execution and reply handshake state machine.
  always_ff @(posedge masterClock) begin
    // NOTE: the reset is sampled synchronously and clears every register,
    // including the latched frame, accumulator and counter, so a reset taken
    // mid-handshake leaves no trace of the aborted frame.
    if (!reset) begin
      state        <= IDLE;
      clearDR      <= 1'b0;
      transmitData <= 1'b0;
      status       <= '0;
      outputData   <= '0;
      rxIndicator  <= 1'b0;
      ctl_q        <= '0;
      data_q       <= '0;
      acc          <= '0;
      cnt          <= '0;
      timer        <= '0;
    end else begin
      // NOTE: every state register uses non-blocking assignment, so all
      // branches below see the values from before this edge.
      case (state)
        IDLE: begin
          if (dataReceived) begin
            ctl_q       <= control;
            data_q      <= inputData;
            rxIndicator <= ~rxIndicator;
            cnt         <= cnt + 16'd1;
            state       <= EXEC;
          end
        end

        EXEC: begin
          status <= {ctl_q[7:4], RES_OK};
          case (ctl_q[3:0])
            OP_NOP:        ;
            OP_ECHO:       outputData <= data_q;
            OP_INVERT:     outputData <= ~data_q;
            OP_ACCUMULATE: begin
              acc        <= acc_sum[DW-1:0];
              outputData <= acc_sum[DW-1:0];
              if (acc_sum[DW]) status[3:0] <= RES_CARRY;
            end
            OP_READ_ACC:   outputData <= acc;
            OP_CLEAR_ACC: begin
              acc        <= '0;
              outputData <= '0;
            end
            OP_COUNT:      outputData <= DW'(cnt);
            default: begin
              outputData  <= '0;
              status[3:0] <= RES_UNKNOWN;
            end
          endcase
          clearDR <= 1'b1;
          state   <= CLEAR;
        end

        CLEAR: begin
          // Keep requesting the buffer release until the interface drops it.
          if (!dataReceived) begin
            clearDR <= 1'b0;
            if (ctl_q[3:0] == OP_NOP) begin
              state <= IDLE;
            end else begin
              transmitData <= 1'b1;
              timer        <= '0;
              state        <= SEND;
            end
          end
        end

        SEND: begin
          // A start seen on the same cycle as the timeout still counts.
          if (transmitting) begin
            transmitData <= 1'b0;
            state        <= WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            transmitData <= 1'b0;
            status[3:0]  <= RES_TX_START;
            state        <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!transmitting) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
